ili9341_pix_feeder: RTL

//  CPU-to-LCD pixel feeder on the picosoc iomem bus, upstream of the ILI9341 byte-stream driver.

---
 rtl/pixfeed_pkg.sv | 25 ++
 rtl/pixfeed_fifo.sv | 56 +++++
 rtl/ili9341_pix_feeder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pixfeed_pkg.sv
// Shared definitions for the ILI9341 pixel feeder: register map, STATUS layout,
// FIFO entry format and output handshake states.
package pixfeed_pkg;

  localparam logic [3:0] ADDR_PIXEL       = 4'h0;
  localparam logic [3:0] ADDR_FILL_COLOUR = 4'h4;
  localparam logic [3:0] ADDR_FILL_COUNT  = 4'h8;
  localparam logic [3:0] ADDR_CTRL        = 4'hC;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FILL      = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int ENTRY_W    = 17;
  localparam int MARKER_BIT = 16;

  typedef enum logic [1:0] {
    O_IDLE     = 2'd0,
    O_ASSERT   = 2'd1,
    O_WAIT_LOW = 2'd2
  } ostate_e;

endpackage

// File: rtl/pixfeed_fifo.sv
// Synchronous FIFO of {marker, rgb565} entries; push is allowed while full when
// a pop happens in the same cycle.
module pixfeed_fifo
  import pixfeed_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_16MHz,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_16MHz) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_16MHz) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/ili9341_pix_feeder.sv
// iomem-bus pixel feeder for the ILI9341 byte-stream driver: FIFO, busy-qualified
// strobe handshake, and an optional fill engine enabled by `define PIXFEED_FILL_EN.
module ili9341_pix_feeder
  import pixfeed_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 17
) (
  input  logic        clk_16MHz,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [3:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        lcd_busy,
  output logic [15:0] lcd_pix_data,
  output logic        lcd_pix_clk,
  output logic        lcd_reset_cursor
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [LVL_W-1:0]   fifo_level;
  logic               is_write, hit_pixel, hit_marker, hit_count, hit_colour;
  logic               stall, accept, cpu_push;
  logic               fill_active, fill_push;
  logic [15:0]        fill_colour;
  logic [31:0]        status;
  logic               unused_bits;
  ostate_e            state_q, state_d;
  logic [15:0]        pix_data_d;
  logic               pix_clk_d, reset_cursor_d;

  assign is_write   = |iomem_wstrb;
  assign hit_pixel  = is_write && (iomem_addr == ADDR_PIXEL);
  assign hit_marker = is_write && (iomem_addr == ADDR_CTRL) && iomem_wdata[0];
  assign hit_count  = is_write && (iomem_addr == ADDR_FILL_COUNT);
  assign hit_colour = is_write && (iomem_addr == ADDR_FILL_COLOUR);

  // CPU pushes wait for FIFO space and never interleave with a running fill.
  assign stall    = ((hit_pixel || hit_marker) && (fifo_full || fill_active)) ||
                    (hit_count && fill_active);
  assign accept   = iomem_valid && !iomem_ready && !stall;
  assign cpu_push = accept && (hit_pixel || hit_marker);

  assign fifo_push  = cpu_push || fill_push;
  assign fifo_wdata = cpu_push ? {hit_marker, hit_marker ? 16'h0 : iomem_wdata[15:0]}
                               : {1'b0, fill_colour};
  assign unused_bits = ^iomem_wdata[31:CNT_W];

`ifdef PIXFEED_FILL_EN
  logic [CNT_W-1:0] fill_count;

  assign fill_push = fill_active && !fifo_full;

  always_ff @(posedge clk_16MHz) begin
    if (!resetn) begin
      fill_active <= 1'b0;
      fill_count  <= '0;
    end else begin
      if (fill_push) begin
        fill_count <= fill_count - 1'b1;
        if (fill_count == CNT_W'(1)) fill_active <= 1'b0;
      end
      if (accept && hit_count) fill_count <= iomem_wdata[CNT_W-1:0];
      // A colour write during a running fill only changes the colour.
      if (accept && hit_colour && !fill_active && (fill_count != '0)) fill_active <= 1'b1;
    end
  end

  always_ff @(posedge clk_16MHz) begin
    if (accept && hit_colour) fill_colour <= iomem_wdata[15:0];
  end
`else
  logic unused_fill;

  assign fill_active = 1'b0;
  assign fill_push   = 1'b0;
  assign fill_colour = 16'h0;
  assign unused_fill = ^{hit_colour, iomem_wdata[CNT_W-1:16]};
`endif

  always_comb begin
    status                           = '0;
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_FILL]                  = fill_active;
    status[ST_BUSY]                  = lcd_busy;
    status[ST_LEVEL_LSB +: LVL_W]    = fifo_level;
  end

  always_ff @(posedge clk_16MHz) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= (accept && !is_write) ? status : '0;
    end
  end

  pixfeed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_16MHz (clk_16MHz),
    .resetn    (resetn),
    .push      (fifo_push),
    .wdata     (fifo_wdata),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d        = state_q;
    pix_data_d     = lcd_pix_data;
    pix_clk_d      = lcd_pix_clk;
    reset_cursor_d = lcd_reset_cursor;
    fifo_pop       = 1'b0;
    unique case (state_q)
      O_IDLE: begin
        if (!fifo_empty && !lcd_busy) begin
          fifo_pop = 1'b1;
          if (fifo_rdata[MARKER_BIT]) begin
            reset_cursor_d = 1'b1;
          end else begin
            pix_data_d = fifo_rdata[15:0];
            pix_clk_d  = 1'b1;
          end
          state_d = O_ASSERT;
        end
      end
      O_ASSERT: begin
        if (lcd_busy) begin
          pix_clk_d      = 1'b0;
          reset_cursor_d = 1'b0;
          state_d        = O_WAIT_LOW;
        end
      end
      // pix_data stays put here: the driver shifts out the low byte late.
      O_WAIT_LOW: begin
        if (!lcd_busy) state_d = O_IDLE;
      end
      default: state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge clk_16MHz) begin
    if (!resetn) begin
      state_q          <= O_IDLE;
      lcd_pix_data     <= '0;
      lcd_pix_clk      <= 1'b0;
      lcd_reset_cursor <= 1'b0;
    end else begin
      state_q          <= state_d;
      lcd_pix_data     <= pix_data_d;
      lcd_pix_clk      <= pix_clk_d;
      lcd_reset_cursor <= reset_cursor_d;
    end
  end

endmodule
